// File: rtl/led_effect_seq_if.sv
// Control/status bundle between the top-level controller (master) and the LED
// effect sequencer (slave).
interface led_effect_seq_if #(
  parameter int LED_W = 8,
  parameter int CNT_W = 32
);
  // Handshake: start is a request that is accepted only on a cycle where the
  // sequencer is idle (busy=0, done=0); acceptance is visible as busy=1 on the
  // next cycle. stop_req acts only while busy. done is a one-cycle pulse that
  // closes every accepted request, whether it completed or was aborted.
  logic             start;
  logic             stop_req;
  logic [1:0]       mode;
  logic [CNT_W-1:0] divisor;
  logic             loop_en;
  logic [LED_W-1:0] leds;
  logic             busy;
  logic             done;
  logic             step_tick;
  logic [1:0]       state;

  modport master (
    output start, stop_req, mode, divisor, loop_en,
    input  leds, busy, done, step_tick, state
  );

  modport slave (
    input  start, stop_req, mode, divisor, loop_en,
    output leds, busy, done, step_tick, state
  );
endinterface

// File: rtl/led_effect_seq.sv
// LED effect sequencer: shift-left, shift-right, bounce and fill patterns with
// a programmable per-pattern dwell, optional looping and abort.
module led_effect_seq #(
  parameter int LED_W = 8,
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  led_effect_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [LED_W-1:0] ONE = LED_W'(1);
  localparam logic [LED_W-1:0] TWO = LED_W'(2);
  localparam logic [LED_W-1:0] MSB = ONE << (LED_W - 1);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [1:0]       mode_q;
  logic             loop_q;
  logic             dir_q;   // 0 = moving left, 1 = moving right
  logic [LED_W-1:0] leds_q;
  logic             busy_q;
  logic             done_q;
  logic             tick_q;

  logic [LED_W-1:0] nxt_leds;
  logic             nxt_dir;
  logic             last_step;
  logic [LED_W-1:0] init_leds;

  assign init_leds = (bus.mode == 2'd1) ? MSB : ONE;

  // Pattern that follows the current one, or last_step when a non-looping
  // effect has shown its final pattern.
  always_comb begin
    nxt_leds  = leds_q;
    nxt_dir   = dir_q;
    last_step = 1'b0;
    case (mode_q)
      2'd0: begin
        if (leds_q[LED_W-1]) begin
          if (loop_q) nxt_leds = ONE;
          else        last_step = 1'b1;
        end else begin
          nxt_leds = leds_q << 1;
        end
      end
      2'd1: begin
        if (leds_q[0]) begin
          if (loop_q) nxt_leds = MSB;
          else        last_step = 1'b1;
        end else begin
          nxt_leds = leds_q >> 1;
        end
      end
      2'd2: begin
        if (!dir_q) begin
          if (leds_q[LED_W-1]) begin
            nxt_dir  = 1'b1;
            nxt_leds = leds_q >> 1;
          end else begin
            nxt_leds = leds_q << 1;
          end
        end else begin
          if (leds_q[0]) begin
            // A looping bounce restarts at bit 1 so bit 0 is not shown twice.
            if (loop_q) begin
              nxt_dir  = 1'b0;
              nxt_leds = TWO;
            end else begin
              last_step = 1'b1;
            end
          end else begin
            nxt_leds = leds_q >> 1;
          end
        end
      end
      default: begin
        if (&leds_q) begin
          if (loop_q) nxt_leds = ONE;
          else        last_step = 1'b1;
        end else begin
          nxt_leds = (leds_q << 1) | ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      mode_q  <= 2'd0;
      loop_q  <= 1'b0;
      dir_q   <= 1'b0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            loop_q  <= bus.loop_en;
            div_q   <= (bus.divisor == '0) ? CNT_W'(1) : bus.divisor;
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.stop_req) begin
            state_q <= S_DONE;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            leds_q  <= (mode_q == 2'd1) ? MSB : ONE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.stop_req || ((cnt_q == div_q - CNT_W'(1)) && last_step)) begin
            state_q <= S_DONE;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (cnt_q == div_q - CNT_W'(1)) begin
            cnt_q  <= '0;
            leds_q <= nxt_leds;
            dir_q  <= nxt_dir;
            tick_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.leds      = leds_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_tick = tick_q;
  assign bus.state     = state_q;

  // init_leds mirrors the LOAD choice for the live mode input; kept for debug visibility.
  logic unused_init;
  assign unused_init = ^init_leds;

endmodule

// File: tb/tb_led_effect_seq.sv
// Self-checking bench for led_effect_seq: expected per-cycle outputs are built
// from the effect pattern lists and compared on every falling edge.
module tb_led_effect_seq;
  localparam int W = 8;

  logic clk;
  logic reset;

  led_effect_seq_if #(.LED_W(W), .CNT_W(32)) bus ();

  led_effect_seq #(.LED_W(W), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ticks    = 0;
  bit chk_en   = 1'b0;

  // {leds, busy, done, step_tick}
  logic [W+2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Pattern k (0-based) of an effect: a looping run is the single run followed
  // by repeats; bounce repeats skip the leading bit-0 pattern.
  function automatic logic [W-1:0] pat(input int m, input int k);
    longint v;
    int pos, r;
    case (m)
      0: v = longint'(1) << (k % W);
      1: v = longint'(1) << (W - 1 - (k % W));
      2: begin
        if (k < 2*W - 1) pos = (k < W) ? k : 2*W - 2 - k;
        else begin
          r   = (k - (2*W - 1)) % (2*W - 2);
          pos = (r < W - 1) ? r + 1 : 2*W - 3 - r;
        end
        v = longint'(1) << pos;
      end
      default: v = (longint'(1) << ((k % W) + 1)) - 1;
    endcase
    return v[W-1:0];
  endfunction

  function automatic int single_len(input int m);
    return (m == 2) ? 2*W - 1 : W;
  endfunction

  // scoreboard: one comparison per cycle once out of reset
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("out", {21'd0, bus.leds, bus.busy, bus.done, bus.step_tick}, {21'd0, e});
      if (bus.step_tick === 1'b1) ticks++;
    end
  end

  // driver: one effect run; abort_at>0 aborts (stop or reset) sampled at edge abort_at after start
  task automatic run(input logic [1:0] m, input int div, input bit lp,
                     input int abort_at, input bit abort_rst, input bit hold);
    logic [W+2:0] tr[$];
    int eff, n, len;
    eff = (div == 0) ? 1 : div;
    n   = lp ? (abort_at / eff + 2) : single_len(int'(m));
    tr.push_back({{W{1'b0}}, 3'b100});
    for (int i = 0; i < n; i++)
      for (int c = 0; c < eff; c++)
        tr.push_back({pat(int'(m), i), 1'b1, 1'b0, (i > 0 && c == 0)});
    if (abort_at > 0)
      while (tr.size() > abort_at) void'(tr.pop_back());
    if (!(abort_at > 0 && abort_rst)) begin
      tr.push_back({{W{1'b0}}, 3'b010});
      tr.push_back({{W{1'b0}}, 3'b000});
    end
    len = tr.size();
    bus.mode     = m;
    bus.divisor  = div;
    bus.loop_en  = lp;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    exp_q = tr;
    bus.mode     = ~m;
    bus.divisor  = 32'd5;
    bus.loop_en  = ~lp;
    for (int j = 0; j < len; j++) begin
      bus.start    = hold && (j <= len - 2);
      bus.stop_req = !abort_rst && abort_at > 0 && j == abort_at - 1;
      reset        = abort_rst && abort_at > 0 && j == abort_at - 1;
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.stop_req = 1'b0;
    reset        = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W+2:0] tr_pin;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stop_req = 1'b0;
    bus.mode     = 2'd0;
    bus.divisor  = 32'd0;
    bus.loop_en  = 1'b0;

    // hand-computed pins on the pattern model
    check("pin_left0",    {24'd0, pat(0, 0)},  32'h01);
    check("pin_left7",    {24'd0, pat(0, 7)},  32'h80);
    check("pin_right0",   {24'd0, pat(1, 0)},  32'h80);
    check("pin_right8",   {24'd0, pat(1, 8)},  32'h80);
    check("pin_bounce7",  {24'd0, pat(2, 7)},  32'h80);
    check("pin_bounce8",  {24'd0, pat(2, 8)},  32'h40);
    check("pin_bounce14", {24'd0, pat(2, 14)}, 32'h01);
    check("pin_bounce15", {24'd0, pat(2, 15)}, 32'h02);
    check("pin_bounce28", {24'd0, pat(2, 28)}, 32'h01);
    check("pin_fill7",    {24'd0, pat(3, 7)},  32'hFF);
    check("pin_fill1",    {24'd0, pat(3, 1)},  32'h03);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // shift-left, div=2, single run: 7 advances, done after E17
    ticks = 0;
    run(2'd0, 2, 1'b0, 0, 1'b0, 1'b0);
    check("left_tick_count", ticks, 7);

    // stop_req in IDLE is ignored
    bus.stop_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.stop_req = 1'b0;

    // shift-right loop, div=1, start held and inputs changed mid-run, stop after 22 cycles
    run(2'd1, 1, 1'b1, 22, 1'b0, 1'b1);
    // bounce single run and looping run
    run(2'd2, 1, 1'b0, 0, 1'b0, 1'b0);
    run(2'd2, 1, 1'b1, 19, 1'b0, 1'b0);
    // fill div=3, then divisor 0 treated as 1, start held into DONE
    run(2'd3, 3, 1'b0, 0, 1'b0, 1'b0);
    run(2'd3, 0, 1'b0, 0, 1'b0, 1'b1);
    // stop on the edge a step is due (div=2, counter=1)
    ticks = 0;
    run(2'd0, 2, 1'b0, 3, 1'b0, 1'b0);
    check("stop_due_ticks", ticks, 0);
    // stop while in LOAD
    run(2'd1, 4, 1'b0, 1, 1'b0, 1'b0);
    // reset mid-WAIT
    run(2'd0, 3, 1'b0, 6, 1'b1, 1'b0);
    check("post_reset_state", {30'd0, bus.state}, 32'd0);
    // clean run after the reset
    run(2'd0, 1, 1'b0, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  logic unused_pin;
  assign unused_pin = 1'b0;
endmodule
